// File: rtl/pong_engine.sv
`default_nettype none
// ============================================================================
// Module      : pong_engine
// Description : Pong game logic and pixel renderer. Advances paddles and ball
//               once per frame on the animate strobe through an
//               IDLE/SERVE/PLAY/POINT/OVER state machine, and produces
//               registered 12-bit RGB per pixel strobe plus both scores.
// Revision    : 1.0 - initial release
// ============================================================================
module pong_engine #(
  parameter int H_RES        = 1024,
  parameter int V_RES        = 768,
  parameter int BALL_SIZE    = 16,
  parameter int PAD_W        = 16,
  parameter int PAD_H        = 128,
  parameter int PAD_X_L      = 32,
  parameter int PAD_X_R      = 976,
  parameter int BALL_SPEED   = 4,
  parameter int PAD_SPEED    = 8,
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pix_stb,
  input  logic        i_animate,
  input  logic        i_active,
  input  logic [10:0] i_x,
  input  logic [10:0] i_y,
  input  logic        i_btn_up_l,
  input  logic        i_btn_dn_l,
  input  logic        i_btn_up_r,
  input  logic        i_btn_dn_r,
  input  logic        i_serve,
  output logic [3:0]  o_red,
  output logic [3:0]  o_green,
  output logic [3:0]  o_blue,
  output logic [3:0]  o_score_l,
  output logic [3:0]  o_score_r,
  output logic        o_game_over
);

  localparam logic [10:0] c_H_RES      = 11'(H_RES);
  localparam logic [10:0] c_V_RES      = 11'(V_RES);
  localparam logic [10:0] c_BALL_SIZE  = 11'(BALL_SIZE);
  localparam logic [10:0] c_PAD_H      = 11'(PAD_H);
  localparam logic [10:0] c_PAD_X_R    = 11'(PAD_X_R);
  localparam logic [10:0] c_FACE_L     = 11'(PAD_X_L + PAD_W);
  localparam logic [10:0] c_PAD_X_L    = 11'(PAD_X_L);
  localparam logic [10:0] c_PAD_W      = 11'(PAD_W);
  localparam logic [10:0] c_BALL_SPEED = 11'(BALL_SPEED);
  localparam logic [10:0] c_PAD_SPEED  = 11'(PAD_SPEED);
  localparam logic [10:0] c_PAD_Y_MAX  = 11'(V_RES - PAD_H);
  localparam logic [10:0] c_BALL_X0    = 11'((H_RES - BALL_SIZE) / 2);
  localparam logic [10:0] c_BALL_Y0    = 11'((V_RES - BALL_SIZE) / 2);
  localparam logic [10:0] c_PAD_Y0     = 11'((V_RES - PAD_H) / 2);
  localparam logic [10:0] c_NET_X0     = 11'(H_RES / 2 - 2);
  localparam logic [10:0] c_NET_X1     = 11'(H_RES / 2 + 1);
  localparam logic [3:0]  c_WIN        = 4'(WIN_SCORE);
  localparam int          c_CNT_W      = $clog2(SERVE_FRAMES);
  localparam logic [c_CNT_W-1:0] c_SERVE_LAST = c_CNT_W'(SERVE_FRAMES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t             r_state;
  logic [10:0]        r_bx, r_by, r_pyl, r_pyr;
  logic               r_dx;          // 1 = moving right
  logic               r_dy;          // 1 = moving down
  logic               r_pt_right;    // last point went to the right player
  logic [3:0]         r_score_l, r_score_r;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_game_over;
  logic [11:0]        r_rgb;

  logic        w_tick, w_start;
  logic [10:0] w_pyl_nxt, w_pyr_nxt, w_bx_nxt, w_by_nxt;
  logic        w_dx_nxt, w_dy_nxt, w_miss_l, w_miss_r, w_ovl_l, w_ovl_r;
  logic [3:0]  w_score_inc;
  logic        w_in_ball, w_in_pad_l, w_in_pad_r, w_in_net;

  // Clamped paddle step; both buttons or neither holds position
  function automatic logic [10:0] f_pad_step(input logic [10:0] y, input logic up, input logic dn);
    logic [10:0] v;
    v = y;
    if (up && !dn)
      v = (y < c_PAD_SPEED) ? 11'd0 : y - c_PAD_SPEED;
    else if (dn && !up)
      v = (y + c_PAD_SPEED > c_PAD_Y_MAX) ? c_PAD_Y_MAX : y + c_PAD_SPEED;
    return v;
  endfunction

  assign w_tick      = i_animate & i_pix_stb;
  assign w_start     = i_serve & i_pix_stb;
  assign w_pyl_nxt   = f_pad_step(r_pyl, i_btn_up_l, i_btn_dn_l);
  assign w_pyr_nxt   = f_pad_step(r_pyr, i_btn_up_r, i_btn_dn_r);
  assign w_ovl_l     = (r_by + c_BALL_SIZE > r_pyl) && (r_by < r_pyl + c_PAD_H);
  assign w_ovl_r     = (r_by + c_BALL_SIZE > r_pyr) && (r_by < r_pyr + c_PAD_H);
  assign w_score_inc = (r_pt_right ? r_score_r : r_score_l) + 4'd1;

  // Next ball position for a PLAY tick; axes are resolved independently
  always_comb begin
    w_bx_nxt = r_bx;
    w_by_nxt = r_by;
    w_dx_nxt = r_dx;
    w_dy_nxt = r_dy;
    w_miss_l = 1'b0;
    w_miss_r = 1'b0;
    if (!r_dy) begin
      if (r_by < c_BALL_SPEED) begin
        w_by_nxt = 11'd0;
        w_dy_nxt = 1'b1;
      end else begin
        w_by_nxt = r_by - c_BALL_SPEED;
      end
    end else begin
      if (r_by + c_BALL_SIZE + c_BALL_SPEED > c_V_RES) begin
        w_by_nxt = c_V_RES - c_BALL_SIZE;
        w_dy_nxt = 1'b0;
      end else begin
        w_by_nxt = r_by + c_BALL_SPEED;
      end
    end
    if (!r_dx) begin
      if (r_bx < c_BALL_SPEED) begin
        w_miss_l = 1'b1;
      end else if (r_bx >= c_FACE_L && r_bx - c_BALL_SPEED < c_FACE_L && w_ovl_l) begin
        w_bx_nxt = c_FACE_L;
        w_dx_nxt = 1'b1;
      end else begin
        w_bx_nxt = r_bx - c_BALL_SPEED;
      end
    end else begin
      if (r_bx + c_BALL_SIZE + c_BALL_SPEED > c_H_RES) begin
        w_miss_r = 1'b1;
      end else if (r_bx + c_BALL_SIZE <= c_PAD_X_R &&
                   r_bx + c_BALL_SIZE + c_BALL_SPEED > c_PAD_X_R && w_ovl_r) begin
        w_bx_nxt = c_PAD_X_R - c_BALL_SIZE;
        w_dx_nxt = 1'b0;
      end else begin
        w_bx_nxt = r_bx + c_BALL_SPEED;
      end
    end
  end

  // Game state machine: per-frame motion, serve countdown and scoring
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_bx        <= c_BALL_X0;
      r_by        <= c_BALL_Y0;
      r_pyl       <= c_PAD_Y0;
      r_pyr       <= c_PAD_Y0;
      r_dx        <= 1'b1;
      r_dy        <= 1'b1;
      r_pt_right  <= 1'b0;
      r_score_l   <= 4'd0;
      r_score_r   <= 4'd0;
      r_cnt       <= '0;
      r_game_over <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) r_state <= S_SERVE;
        end
        S_SERVE: begin
          if (w_tick) begin
            r_pyl <= w_pyl_nxt;
            r_pyr <= w_pyr_nxt;
            if (r_cnt == c_SERVE_LAST) begin
              r_cnt   <= '0;
              r_state <= S_PLAY;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_PLAY: begin
          if (w_tick) begin
            r_pyl <= w_pyl_nxt;
            r_pyr <= w_pyr_nxt;
            r_bx  <= w_bx_nxt;
            r_by  <= w_by_nxt;
            r_dx  <= w_dx_nxt;
            r_dy  <= w_dy_nxt;
            if (w_miss_l || w_miss_r) begin
              r_pt_right <= w_miss_l;
              r_state    <= S_POINT;
            end
          end
        end
        S_POINT: begin
          if (w_tick) begin
            if (r_pt_right) r_score_r <= w_score_inc;
            else            r_score_l <= w_score_inc;
            if (w_score_inc == c_WIN) begin
              r_state     <= S_OVER;
              r_game_over <= 1'b1;
            end else begin
              // Next serve heads toward the player who lost the point
              r_bx    <= c_BALL_X0;
              r_by    <= c_BALL_Y0;
              r_dx    <= ~r_pt_right;
              r_state <= S_SERVE;
            end
          end
        end
        S_OVER: begin
          if (w_start) begin
            r_score_l   <= 4'd0;
            r_score_r   <= 4'd0;
            r_bx        <= c_BALL_X0;
            r_by        <= c_BALL_Y0;
            r_cnt       <= '0;
            r_game_over <= 1'b0;
            r_state     <= S_SERVE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_in_ball  = (i_x >= r_bx) && (i_x < r_bx + c_BALL_SIZE) &&
                      (i_y >= r_by) && (i_y < r_by + c_BALL_SIZE);
  assign w_in_pad_l = (i_x >= c_PAD_X_L) && (i_x < c_PAD_X_L + c_PAD_W) &&
                      (i_y >= r_pyl) && (i_y < r_pyl + c_PAD_H);
  assign w_in_pad_r = (i_x >= c_PAD_X_R) && (i_x < c_PAD_X_R + c_PAD_W) &&
                      (i_y >= r_pyr) && (i_y < r_pyr + c_PAD_H);
  assign w_in_net   = (i_x >= c_NET_X0) && (i_x <= c_NET_X1) && !i_y[4];

  // Pixel colour, registered once per pixel strobe with fixed priority
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rgb <= 12'h000;
    end else if (i_pix_stb) begin
      if (!i_active)       r_rgb <= 12'h000;
      else if (w_in_ball)  r_rgb <= 12'hFFF;
      else if (w_in_pad_l) r_rgb <= 12'h0FF;
      else if (w_in_pad_r) r_rgb <= 12'hFF0;
      else if (w_in_net)   r_rgb <= 12'h888;
      else                 r_rgb <= 12'h000;
    end
  end

  assign o_red       = r_rgb[11:8];
  assign o_green     = r_rgb[7:4];
  assign o_blue      = r_rgb[3:0];
  assign o_score_l   = r_score_l;
  assign o_score_r   = r_score_r;
  assign o_game_over = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_pong_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_pong_engine
// Description : Randomised scoreboard bench for pong_engine. A game model
//               predicts colour, scores and game-over for every pixel strobe;
//               a monitor compares the DUT one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_engine;

  logic        clk = 1'b0, rst = 1'b1;
  logic        stb = 1'b0, anim = 1'b0, act = 1'b0, serve = 1'b0;
  logic [10:0] px = '0, py = '0;
  logic        bul = 1'b0, bdl = 1'b0, bur = 1'b0, bdr = 1'b0;
  logic [3:0]  red, green, blue, score_l, score_r;
  logic        game_over;

  pong_engine dut (
    .i_clk(clk), .i_rst(rst), .i_pix_stb(stb), .i_animate(anim), .i_active(act),
    .i_x(px), .i_y(py),
    .i_btn_up_l(bul), .i_btn_dn_l(bdl), .i_btn_up_r(bur), .i_btn_dn_r(bdr),
    .i_serve(serve),
    .o_red(red), .o_green(green), .o_blue(blue),
    .o_score_l(score_l), .o_score_r(score_r), .o_game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] rgb;
    logic [3:0]  sl;
    logic [3:0]  sr;
    logic        go;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s at %0t: got %h, want %h", name, $time, got, want);
  endtask

  // ---------------- reference game model ----------------
  localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_POINT = 3, M_OVER = 4;
  int m_state, m_bx, m_by, m_pyl, m_pyr, m_sl, m_sr, m_ticks;
  bit m_right, m_down, m_right_scored, m_over;

  task automatic model_reset();
    m_state = M_IDLE; m_bx = 504; m_by = 376; m_pyl = 320; m_pyr = 320;
    m_right = 1; m_down = 1; m_sl = 0; m_sr = 0; m_ticks = 0; m_over = 0;
    m_right_scored = 0;
  endtask

  function automatic bit inside_box(int x, int y, int rx, int ry, int w, int h);
    return x >= rx && x < rx + w && y >= ry && y < ry + h;
  endfunction

  function automatic logic [11:0] exp_pix(int x, int y, bit a);
    if (!a)                                   return 12'h000;
    if (inside_box(x, y, m_bx, m_by, 16, 16)) return 12'hFFF;
    if (inside_box(x, y, 32, m_pyl, 16, 128)) return 12'h0FF;
    if (inside_box(x, y, 976, m_pyr, 16, 128)) return 12'hFF0;
    if (x >= 510 && x <= 513 && (y % 32) < 16) return 12'h888;
    return 12'h000;
  endfunction

  function automatic int paddle_move(int p, bit up, bit dn);
    if (up && !dn) return (p - 8 < 0) ? 0 : p - 8;
    if (dn && !up) return (p + 8 > 640) ? 640 : p + 8;
    return p;
  endfunction

  function automatic bit ball_meets(int ball_y, int pad_y);
    return ball_y + 16 > pad_y && ball_y < pad_y + 128;
  endfunction

  task automatic model_cycle(bit s, bit a, bit sv, bit ul, bit dl, bit ur, bit dr);
    bit tick;
    int nx, ny;
    tick = s & a;
    case (m_state)
      M_IDLE: if (sv && s) m_state = M_SERVE;
      M_SERVE: if (tick) begin
        m_pyl = paddle_move(m_pyl, ul, dl);
        m_pyr = paddle_move(m_pyr, ur, dr);
        m_ticks++;
        if (m_ticks == 60) begin m_ticks = 0; m_state = M_PLAY; end
      end
      M_PLAY: if (tick) begin
        if (m_right) begin
          nx = m_bx + 4;
          if (nx + 16 > 1024) begin m_right_scored = 0; m_state = M_POINT; end
          else if (m_bx + 16 <= 976 && nx + 16 > 976 && ball_meets(m_by, m_pyr)) begin
            m_bx = 960; m_right = 0;
          end else m_bx = nx;
        end else begin
          nx = m_bx - 4;
          if (nx < 0) begin m_right_scored = 1; m_state = M_POINT; end
          else if (m_bx >= 48 && nx < 48 && ball_meets(m_by, m_pyl)) begin
            m_bx = 48; m_right = 1;
          end else m_bx = nx;
        end
        if (m_down) begin
          ny = m_by + 4;
          if (ny + 16 > 768) begin m_by = 752; m_down = 0; end else m_by = ny;
        end else begin
          ny = m_by - 4;
          if (ny < 0) begin m_by = 0; m_down = 1; end else m_by = ny;
        end
        m_pyl = paddle_move(m_pyl, ul, dl);
        m_pyr = paddle_move(m_pyr, ur, dr);
      end
      M_POINT: if (tick) begin
        if (m_right_scored) m_sr++; else m_sl++;
        if (m_sl == 9 || m_sr == 9) begin
          m_state = M_OVER; m_over = 1;
        end else begin
          m_bx = 504; m_by = 376; m_right = !m_right_scored; m_state = M_SERVE;
        end
      end
      M_OVER: if (sv && s) begin
        m_sl = 0; m_sr = 0; m_bx = 504; m_by = 376; m_ticks = 0; m_over = 0;
        m_state = M_SERVE;
      end
      default: m_state = M_IDLE;
    endcase
  endtask

  // ---------------- monitor ----------------
  logic stb_q = 1'b0;
  always @(posedge clk) stb_q <= stb & ~rst;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (stb_q) begin
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL scoreboard_empty at %0t: got output, want queued entry", $time);
        end else begin
          e = q.pop_front();
          chk("rgb",       {20'd0, red, green, blue}, {20'd0, e.rgb});
          chk("score_l",   {28'd0, score_l},          {28'd0, e.sl});
          chk("score_r",   {28'd0, score_r},          {28'd0, e.sr});
          chk("game_over", {31'd0, game_over},        {31'd0, e.go});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1; stb = 0; anim = 0; serve = 0;
    model_reset();
    #1;
    chk("reset_rgb",   {20'd0, red, green, blue}, 32'd0);
    chk("reset_sl",    {28'd0, score_l},          32'd0);
    chk("reset_sr",    {28'd0, score_r},          32'd0);
    chk("reset_over",  {31'd0, game_over},        32'd0);
    @(negedge clk); #1;
    rst = 0;
  endtask

  function automatic logic [10:0] clamp11(int v);
    if (v < 0) return 11'd0;
    if (v > 2047) return 11'd2047;
    return 11'(v);
  endfunction

  task automatic drive_cycle();
    int sel, tx, ty;
    exp_t e;
    @(negedge clk); #1;
    stb   = ($urandom_range(0, 3) != 0);
    anim  = $urandom_range(0, 1);
    act   = ($urandom_range(0, 9) != 0);
    serve = ($urandom_range(0, 63) == 0);
    // Paddles mostly chase the ball so rallies include hits, sometimes mash
    if ($urandom_range(0, 2) != 0) begin
      bul = (m_pyl + 64 > m_by + 8); bdl = (m_pyl + 64 < m_by + 8);
      bur = (m_pyr + 64 > m_by + 8); bdr = (m_pyr + 64 < m_by + 8);
    end else begin
      {bul, bdl, bur, bdr} = 4'($urandom_range(0, 15));
    end
    sel = $urandom_range(0, 3);
    if (sel <= 1) begin
      tx = m_bx + int'($urandom_range(0, 40)) - 12;
      ty = m_by + int'($urandom_range(0, 40)) - 12;
    end else if (sel == 2) begin
      tx = ($urandom_range(0, 1) ? 976 : 32) + int'($urandom_range(0, 32)) - 8;
      ty = (tx > 512 ? m_pyr : m_pyl) + int'($urandom_range(0, 160)) - 16;
    end else begin
      tx = $urandom_range(0, 1023);
      ty = $urandom_range(0, 767);
    end
    px = clamp11(tx);
    py = clamp11(ty);
    e.rgb = exp_pix(int'(px), int'(py), act);
    model_cycle(stb, anim, serve, bul, bdl, bur, bdr);
    e.sl = 4'(m_sl);
    e.sr = 4'(m_sr);
    e.go = m_over;
    if (stb) q.push_back(e);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();
    for (int i = 0; i < 60000; i++) begin
      if (i == 20000 || i == 45000) do_reset();
      drive_cycle();
    end
    @(negedge clk); #1;
    stb = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
